// File: rtl/gol_sim_scheduler_if.sv
// ============================================================================
// Module : gol_sim_scheduler_if
// Brief  : Cell-edit request channel and shared field write port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gol_sim_scheduler_if #(
  parameter int FIELD_W = 64,
  parameter int FIELD_H = 48
);
  localparam int X_ADR_SIZE = $clog2(FIELD_W);
  localparam int Y_ADR_SIZE = $clog2(FIELD_H);

  logic                  i_edit_req;
  logic [X_ADR_SIZE-1:0] i_edit_x;
  logic [Y_ADR_SIZE-1:0] i_edit_y;
  logic                  i_edit_val;
  logic                  o_edit_ack;
  logic                  o_wr_en;
  logic [X_ADR_SIZE-1:0] o_wr_x;
  logic [Y_ADR_SIZE-1:0] o_wr_y;
  logic                  o_wr_val;

  modport slave (
    input  i_edit_req, i_edit_x, i_edit_y, i_edit_val,
    output o_edit_ack, o_wr_en, o_wr_x, o_wr_y, o_wr_val
  );

  modport master (
    output i_edit_req, i_edit_x, i_edit_y, i_edit_val,
    input  o_edit_ack, o_wr_en, o_wr_x, o_wr_y, o_wr_val
  );
endinterface

`default_nettype wire

// File: rtl/gol_sim_scheduler.sv
// ============================================================================
// Module : gol_sim_scheduler
// Brief  : Run/pause/step sequencer for the generation iterator; owns the
//          field write port (user edits vs. full-field clear sweep).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gol_sim_scheduler #(
  parameter int FIELD_W  = 64,
  parameter int FIELD_H  = 48,
  parameter int PERIOD_W = 24,
  parameter int GEN_W    = 16
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  input  wire logic                i_run_toggle,
  input  wire logic                i_step,
  input  wire logic                i_clear,
  input  wire logic [PERIOD_W-1:0] i_period,
  input  wire logic                i_is_simulating,
  output      logic                o_go,
  output      logic                o_running,
  output      logic                o_busy,
  output      logic [GEN_W-1:0]    o_gen,
  gol_sim_scheduler_if.slave       edit_bus
);

  localparam int X_ADR_SIZE = $clog2(FIELD_W);
  localparam int Y_ADR_SIZE = $clog2(FIELD_H);
  localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - 1);
  localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);

  typedef enum logic [2:0] {
    ST_PAUSED   = 3'd0,
    ST_RUN_WAIT = 3'd1,
    ST_LAUNCH   = 3'd2,
    ST_SIM      = 3'd3,
    ST_CLEAR    = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic                  run_q, run_d;
  logic [PERIOD_W-1:0]   timer_q, timer_d;
  logic [GEN_W-1:0]      gen_q, gen_d;
  logic                  clr_pend_q, clr_pend_d;
  logic [X_ADR_SIZE-1:0] clr_x_q, clr_x_d;
  logic [Y_ADR_SIZE-1:0] clr_y_q, clr_y_d;

  logic edit_ok;
  logic run_next;
  logic in_clear;
  logic edit_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_PAUSED;
      run_q      <= 1'b0;
      timer_q    <= '0;
      gen_q      <= '0;
      clr_pend_q <= 1'b0;
      clr_x_q    <= '0;
      clr_y_q    <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      timer_q    <= timer_d;
      gen_q      <= gen_d;
      clr_pend_q <= clr_pend_d;
      clr_x_q    <= clr_x_d;
      clr_y_q    <= clr_y_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    timer_d    = timer_q;
    gen_d      = gen_q;
    clr_pend_d = clr_pend_q;
    clr_x_d    = clr_x_q;
    clr_y_d    = clr_y_q;
    edit_ok    = 1'b0;
    run_next   = run_q ^ i_run_toggle;

    unique case (state_q)
      ST_PAUSED: begin
        if (i_clear) begin
          state_d = ST_CLEAR;
        end else if (i_step) begin
          state_d = ST_LAUNCH;
        end else if (i_run_toggle) begin
          state_d = ST_RUN_WAIT;
          run_d   = 1'b1;
          timer_d = '0;
        end else begin
          edit_ok = 1'b1;
        end
      end

      ST_RUN_WAIT: begin
        if (i_clear) begin
          state_d = ST_CLEAR;
          run_d   = 1'b0;
        end else if (i_run_toggle) begin
          state_d = ST_PAUSED;
          run_d   = 1'b0;
        end else if (timer_q == i_period) begin
          state_d = ST_LAUNCH;
        end else begin
          timer_d = timer_q + PERIOD_W'(1);
          edit_ok = 1'b1;
        end
      end

      ST_LAUNCH: begin
        state_d = ST_SIM;
        run_d   = run_next;
        if (i_clear) clr_pend_d = 1'b1;
      end

      // Toggles and clears are absorbed while the iterator runs; they only
      // steer where the scheduler goes once the sweep finishes.
      ST_SIM: begin
        run_d = run_next;
        if (i_clear) clr_pend_d = 1'b1;
        if (!i_is_simulating) begin
          gen_d   = gen_q + GEN_W'(1);
          timer_d = '0;
          if (clr_pend_q || i_clear) begin
            state_d    = ST_CLEAR;
            run_d      = 1'b0;
            clr_pend_d = 1'b0;
          end else if (run_next) begin
            state_d = ST_RUN_WAIT;
          end else begin
            state_d = ST_PAUSED;
          end
        end
      end

      ST_CLEAR: begin
        if (clr_x_q == X_LAST) begin
          clr_x_d = '0;
          if (clr_y_q == Y_LAST) begin
            clr_y_d = '0;
            state_d = ST_PAUSED;
            run_d   = 1'b0;
            gen_d   = '0;
          end else begin
            clr_y_d = clr_y_q + Y_ADR_SIZE'(1);
          end
        end else begin
          clr_x_d = clr_x_q + X_ADR_SIZE'(1);
        end
      end

      default: begin
        state_d = ST_PAUSED;
      end
    endcase
  end

  // Edits share the port combinationally; the clear sweep drives registered addresses.
  assign in_clear = (state_q == ST_CLEAR);
  assign edit_ack = edit_ok & edit_bus.i_edit_req;

  assign edit_bus.o_edit_ack = edit_ack;
  assign edit_bus.o_wr_en    = in_clear | edit_ack;
  assign edit_bus.o_wr_x     = in_clear ? clr_x_q : (edit_ack ? edit_bus.i_edit_x : '0);
  assign edit_bus.o_wr_y     = in_clear ? clr_y_q : (edit_ack ? edit_bus.i_edit_y : '0);
  assign edit_bus.o_wr_val   = edit_ack & edit_bus.i_edit_val;

  assign o_go      = (state_q == ST_LAUNCH);
  assign o_busy    = (state_q == ST_LAUNCH) || (state_q == ST_SIM) || in_clear;
  assign o_running = run_q;
  assign o_gen     = gen_q;

endmodule

`default_nettype wire

// File: tb/tb_gol_sim_scheduler.sv
// ============================================================================
// Module : tb_gol_sim_scheduler
// Brief  : Directed/randomized self-checking bench for gol_sim_scheduler.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gol_sim_scheduler;

  localparam int FW = 4;
  localparam int FH = 3;
  localparam int PW = 8;
  localparam int GW = 4;
  localparam int XW = $clog2(FW);
  localparam int YW = $clog2(FH);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_run_toggle = 1'b0;
  logic          i_step = 1'b0;
  logic          i_clear = 1'b0;
  logic [PW-1:0] i_period = '0;
  logic          i_is_simulating = 1'b0;
  logic          o_go, o_running, o_busy;
  logic [GW-1:0] o_gen;

  gol_sim_scheduler_if #(.FIELD_W(FW), .FIELD_H(FH)) bus ();

  gol_sim_scheduler #(
    .FIELD_W (FW),
    .FIELD_H (FH),
    .PERIOD_W(PW),
    .GEN_W   (GW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_run_toggle   (i_run_toggle),
    .i_step         (i_step),
    .i_clear        (i_clear),
    .i_period       (i_period),
    .i_is_simulating(i_is_simulating),
    .o_go           (o_go),
    .o_running      (o_running),
    .o_busy         (o_busy),
    .o_gen          (o_gen),
    .edit_bus       (bus)
  );

  always #5 clk = ~clk;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   busy_len = 1;
  int   sim_cnt  = 0;
  logic mem   [FH][FW];
  logic exp_f [FH][FW];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: capture the write port into the field model, advance the edge,
  // retire pulses/acked requests, and run the iterator model.
  task automatic tick();
    logic acked;
    #1;
    if (bus.o_wr_en && (int'(bus.o_wr_y) < FH)) mem[bus.o_wr_y][bus.o_wr_x] = bus.o_wr_val;
    acked = bus.i_edit_req & bus.o_edit_ack;
    @(posedge clk);
    #1;
    i_step = 1'b0;
    i_run_toggle = 1'b0;
    i_clear = 1'b0;
    if (acked) bus.i_edit_req = 1'b0;
    if (o_go) sim_cnt = busy_len + 1;
    else if (sim_cnt > 0) sim_cnt--;
    i_is_simulating = (sim_cnt != 0);
  endtask

  task automatic cmp_field(input string tag);
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < FW; x++)
        chk(tag, 32'(mem[y][x]), 32'(exp_f[y][x]));
  endtask

  task automatic paused_edit(input logic [XW-1:0] x, input logic [YW-1:0] y, input logic v);
    bus.i_edit_x = x;
    bus.i_edit_y = y;
    bus.i_edit_val = v;
    bus.i_edit_req = 1'b1;
    #1;
    chk("edit_ack", 32'(bus.o_edit_ack), 32'd1);
    chk("edit_wr", {bus.o_wr_en, bus.o_wr_x, bus.o_wr_y, bus.o_wr_val}, {1'b1, x, y, v});
    exp_f[y][x] = v;
    tick();
  endtask

  task automatic step_wait(output int cycles, output int gos);
    i_step = 1'b1;
    tick();
    cycles = 0;
    gos = 0;
    while (o_busy && cycles < 500) begin
      gos += int'(o_go);
      tick();
      cycles++;
    end
  endtask

  initial begin
    int cycles, gos, nack, p, l, g, last, nogo;
    logic [XW-1:0] ex;
    logic [YW-1:0] ey;
    logic [GW-1:0] egen;

    bus.i_edit_req = 1'b0;
    bus.i_edit_x = '0;
    bus.i_edit_y = '0;
    bus.i_edit_val = 1'b0;
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < FW; x++) begin
        mem[y][x] = 1'b0;
        exp_f[y][x] = 1'b0;
      end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", {o_go, bus.o_edit_ack, bus.o_wr_en, bus.o_wr_val, o_running, o_busy}, 0);
    chk("reset_xy", {bus.o_wr_x, bus.o_wr_y}, 0);
    chk("reset_gen", 32'(o_gen), 0);
    rst_n = 1'b1;
    tick();

    // Single step, iterator busy for 10 cycles
    busy_len = 10;
    i_step = 1'b1;
    tick();
    chk("step_go", 32'(o_go), 1);
    chk("step_busy", 32'(o_busy), 1);
    cycles = 0;
    gos = 0;
    while (o_busy && cycles < 500) begin
      gos += int'(o_go);
      tick();
      cycles++;
    end
    chk("step_cycles", cycles, 32'(busy_len + 2));
    chk("step_go_count", gos, 1);
    chk("step_gen", 32'(o_gen), 1);
    chk("step_running", 32'(o_running), 0);
    egen = 4'd1;

    // Random edits while paused
    repeat (6) paused_edit(XW'($urandom_range(0, FW - 1)), YW'($urandom_range(0, FH - 1)), 1'($urandom));
    #1;
    chk("edit_idle_ack", {bus.o_edit_ack, bus.o_wr_en}, 0);
    cmp_field("field_edits");

    // Edit request held across a step: no ack until the sweep ends
    busy_len = 3;
    i_step = 1'b1;
    tick();
    bus.i_edit_x = 2'd3;
    bus.i_edit_y = 2'd2;
    bus.i_edit_val = 1'b1;
    bus.i_edit_req = 1'b1;
    nack = 0;
    cycles = 0;
    while (o_busy && cycles < 100) begin
      #1;
      if (bus.o_edit_ack || bus.o_wr_en) nack++;
      tick();
      cycles++;
    end
    chk("sim_no_ack", nack, 0);
    #1;
    chk("post_sim_ack", 32'(bus.o_edit_ack), 1);
    chk("post_sim_wr", {bus.o_wr_en, bus.o_wr_x, bus.o_wr_y, bus.o_wr_val}, {1'b1, 2'd3, 2'd2, 1'b1});
    exp_f[2][3] = 1'b1;
    tick();
    egen = egen + 4'd1;
    chk("step2_gen", 32'(o_gen), 32'(egen));

    // Run mode with random period and iterator latency
    p = $urandom_range(0, 6);
    l = $urandom_range(1, 5);
    busy_len = l;
    i_period = PW'(p);
    i_run_toggle = 1'b1;
    tick();
    g = p + l + 3;
    last = p + 1 + 3 * g + l + 2;
    for (int c = 0; c <= last; c++) begin
      if (c == 0) i_step = 1'b1;
      if (c == last) i_run_toggle = 1'b1;
      #1;
      chk("run_go", 32'(o_go), 32'((c >= p + 1) && (((c - (p + 1)) % g) == 0)));
      if (c == 0) chk("run_flag", 32'(o_running), 1);
      if (c == last) chk("run_gen", 32'(o_gen), 32'(egen + 4'd4));
      tick();
    end
    egen = egen + 4'd4;
    chk("paused_flag", 32'(o_running), 0);
    nogo = 0;
    for (int c = 0; c < 3 * g; c++) begin
      if (o_go) nogo++;
      tick();
    end
    chk("paused_no_go", nogo, 0);

    // Clear and toggle together while running: clear wins
    i_period = 8'd3;
    busy_len = 2;
    i_run_toggle = 1'b1;
    tick();
    tick();
    i_clear = 1'b1;
    i_run_toggle = 1'b1;
    tick();
    for (int k = 0; k < FW * FH; k++) begin
      ex = XW'(k % FW);
      ey = YW'(k / FW);
      #1;
      chk("clr_ctl", {bus.o_wr_en, bus.o_wr_val, o_busy}, 3'b101);
      chk("clr_xy", {bus.o_wr_x, bus.o_wr_y}, {ex, ey});
      if (k == 0) chk("clr_running", 32'(o_running), 0);
      tick();
    end
    chk("clr_end", {o_busy, bus.o_wr_en, o_running}, 0);
    chk("clr_gen", 32'(o_gen), 0);
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < FW; x++) exp_f[y][x] = 1'b0;
    cmp_field("field_clear");
    egen = '0;

    // Clear pulse during SIM is deferred to SIM exit
    repeat (3) paused_edit(XW'($urandom_range(0, FW - 1)), YW'($urandom_range(0, FH - 1)), 1'b1);
    busy_len = 4;
    i_step = 1'b1;
    tick();
    tick();
    i_clear = 1'b1;
    tick();
    cycles = 0;
    while (!bus.o_wr_en && cycles < 100) begin
      tick();
      cycles++;
    end
    chk("deferred_clr_delay", cycles, 32'(busy_len));
    chk("deferred_clr_gen", 32'(o_gen), 1);
    repeat (FW * FH) tick();
    chk("deferred_clr_end", {o_busy, o_running}, 0);
    chk("deferred_clr_gen0", 32'(o_gen), 0);
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < FW; x++) exp_f[y][x] = 1'b0;
    cmp_field("field_clear2");

    // Asynchronous reset partway through a clear sweep
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < FW; x++) paused_edit(XW'(x), YW'(y), 1'b1);
    i_clear = 1'b1;
    tick();
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_flags", {o_go, bus.o_edit_ack, bus.o_wr_en, bus.o_wr_val, o_running, o_busy}, 0);
    chk("areset_xy", {bus.o_wr_x, bus.o_wr_y}, 0);
    chk("areset_gen", 32'(o_gen), 0);
    for (int k = 0; k < 5; k++) exp_f[k / FW][k % FW] = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    cmp_field("field_partial");

    // Generation counter wrap
    busy_len = 1;
    egen = '0;
    for (int i = 0; i < 16; i++) begin
      step_wait(cycles, gos);
      egen = egen + 4'd1;
      chk("wrap_gen", 32'(o_gen), 32'(egen));
    end
    chk("wrap_zero", 32'(o_gen), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gol_sim_scheduler.md
Name: gol_sim_scheduler

Overview:
- Sequences the generation iterator: issues its one-cycle start pulse and waits for its sweep to finish.
- Supports run, pause and single-step modes, with a programmable inter-generation period.
- Owns the shared field write port, arbitrating user cell edits against a full-field clear sweep.
- Sits between the UI/button logic and the iterator plus field memories; counts completed generations for display.

Parameters:
- FIELD_W, 64, field width in cells; X_ADR_SIZE = $clog2(FIELD_W).
- FIELD_H, 48, field height in cells; Y_ADR_SIZE = $clog2(FIELD_H).
- PERIOD_W, 24, width of the period timer and of i_period.
- GEN_W, 16, width of the generation counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- i_run_toggle  in  1  one-cycle pulse; toggles run/pause
- i_step  in  1  one-cycle pulse; single generation, honoured only while paused
- i_clear  in  1  one-cycle pulse; zero the displayed field, then pause
- i_period  in  PERIOD_W  idle cycles between generations while running
- i_is_simulating  in  1  iterator busy flag
- o_go  out  1  one-cycle start pulse to iterator
- i_edit_req  in  1  level request to write one cell
- i_edit_x  in  X_ADR_SIZE  edit column
- i_edit_y  in  Y_ADR_SIZE  edit row
- i_edit_val  in  1  edit cell value
- o_edit_ack  out  1  edit accepted this cycle
- o_wr_en  out  1  field write enable
- o_wr_x  out  X_ADR_SIZE  write column
- o_wr_y  out  Y_ADR_SIZE  write row
- o_wr_val  out  1  write data
- o_running  out  1  run mode flag
- o_busy  out  1  high in LAUNCH, SIM and CLEAR
- o_gen  out  GEN_W  completed generation count

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
- Reset values: state PAUSED; o_go, o_edit_ack, o_wr_en, o_wr_val, o_running, o_busy all 0; o_wr_x, o_wr_y, o_gen, timer all 0.
- States: PAUSED, RUN_WAIT, LAUNCH, SIM, CLEAR.
- PAUSED, event priority: i_clear > i_step > i_run_toggle > edit.
  - clear -> CLEAR.
  - step -> LAUNCH, run flag stays 0.
  - toggle -> RUN_WAIT, run flag 1, timer 0.
- RUN_WAIT, event priority: i_clear > i_run_toggle > timer expiry > edit.
  - clear -> CLEAR, run flag 0.
  - toggle -> PAUSED, run flag 0.
  - timer == i_period -> LAUNCH; otherwise timer increments.
  - i_period = 0 launches on the cycle after entry.
  - i_step is ignored.
- LAUNCH: o_go = 1 for exactly this cycle -> SIM.
- SIM: wait while i_is_simulating = 1.
  - On the first cycle with i_is_simulating = 0: o_gen increments (wraps at 2^GEN_W).
  - Next state RUN_WAIT (timer 0) if run flag is set, else PAUSED.
- Events during LAUNCH/SIM:
  - i_run_toggle toggles the run flag; it takes effect on exit from SIM.
  - i_clear is latched as pending; CLEAR is entered on SIM exit instead of PAUSED/RUN_WAIT, with run flag 0.
  - i_step is dropped.
- CLEAR:
  - o_wr_en = 1, o_wr_val = 0; o_wr_x/o_wr_y are registered and sweep x fastest from (0,0) to (FIELD_W-1, FIELD_H-1).
  - Takes exactly FIELD_W*FIELD_H cycles; no wrap beyond the last cell.
  - Then -> PAUSED, run flag 0, o_gen = 0.
  - Pulses during CLEAR are ignored.
- Edits:
  - o_edit_ack = i_edit_req, combinational, only in PAUSED/RUN_WAIT and only when no higher-priority event fires that cycle.
  - On ack: o_wr_en = 1 and o_wr_x/y/val = i_edit_* in the same cycle.
  - Otherwise o_wr_en = 0 outside CLEAR.
  - The requester holds its request until ack; every acked cycle is one write.
- The write port never writes in LAUNCH or SIM.
- o_running reflects the run flag, registered.
- Async reset mid-SIM or mid-CLEAR returns immediately to reset values; a partially cleared field is left as is.

Test Plan:
- Reset, then i_step pulse; iterator model holds busy 10 cycles -> o_go high exactly 1 cycle, o_busy high, o_gen=1, back to PAUSED, o_running=0.
- i_period=5, toggle run, busy=3 cycles -> o_go pulses spaced 1+5+1+3+... per generation; after 4 generations o_gen=4; toggle again -> no further o_go.
- Edit req (x=3,y=2,val=1) in PAUSED -> same-cycle ack, o_wr_en=1, x=3, y=2, val=1; req held during SIM -> no ack until SIM exit.
- FIELD_W=4, FIELD_H=3: i_clear -> 12 consecutive writes of 0, (0,0)..(3,2) in x-fastest order; then PAUSED with o_gen=0.
- i_clear and i_run_toggle in the same cycle while running -> CLEAR wins; ends PAUSED, o_running=0.
- i_clear pulse during SIM -> CLEAR starts the cycle after SIM exits.
- Assert rst_n=0 mid-CLEAR -> all outputs return to 0 asynchronously.
- o_gen preset near 2^GEN_W-1 via steps -> wraps to 0.
